// File: rtl/servo_position_controller.sv
// Closed-loop servo positioning engine: shortest-path angle error, ramp-limited
// proportional duty, reversal through a brake step, stall fault, host status word.
module servo_position_controller #(
  parameter int unsigned ANGLE_W     = 12,
  parameter int unsigned DUTY_W      = 8,
  parameter int unsigned DEADBAND    = 4,
  parameter int unsigned KP_SHIFT    = 2,
  parameter int unsigned MIN_DUTY    = 16,
  parameter int unsigned RAMP_STEP   = 8,
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned STALL_TICKS = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_strobe,
  input  logic [31:0]        input_reg,
  input  logic [ANGLE_W-1:0] current_angle,
  output logic [DUTY_W-1:0]  motor_duty,
  output logic               clockwise,
  output logic               brake,
  output logic               pwm_on,
  output logic [ANGLE_W-1:0] display_angle,
  output logic [31:0]        status_reg
);

  localparam int unsigned TICK_W   = $clog2(TICK_DIV);
  localparam int unsigned STALL_W  = $clog2(STALL_TICKS + 1);
  localparam int unsigned DUTY_MAX = 2**DUTY_W - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_REV   = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [ANGLE_W-1:0]   target_q, target_d;
  logic                 enable_q, enable_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [ANGLE_W-1:0]   min_err_q, min_err_d;
  logic [DUTY_W-1:0]    duty_q, duty_d;
  logic                 cw_q, cw_d;
  logic                 rev_brake_q, rev_brake_d;
  logic [ANGLE_W-1:0]   display_q, display_d;

  logic                 tick, clear_req, start_move;
  logic [ANGLE_W-1:0]   diff, err_mag, prop;
  logic                 err_neg, want_cw, on_tgt;
  logic [DUTY_W-1:0]    duty_tgt, duty_dn;

  function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    if (32'(tgt) > 32'(cur) + RAMP_STEP) return DUTY_W'(32'(cur) + RAMP_STEP);
    if (32'(cur) > 32'(tgt) + RAMP_STEP) return DUTY_W'(32'(cur) - RAMP_STEP);
    return tgt;
  endfunction

  assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign clear_req  = cmd_strobe & input_reg[17];
  assign enable_d   = cmd_strobe ? input_reg[16] : enable_q;
  assign target_d   = cmd_strobe ? input_reg[ANGLE_W-1:0] : target_q;
  assign display_d  = tick ? current_angle : display_q;

  // The half-circle error (MSB set, rest zero) negates to itself and is taken as clockwise.
  assign diff    = target_q - current_angle;
  assign err_neg = diff[ANGLE_W-1];
  assign err_mag = err_neg ? (~diff + 1'b1) : diff;
  assign want_cw = !err_neg || (diff == {1'b1, {(ANGLE_W-1){1'b0}}});
  assign on_tgt  = (err_mag <= ANGLE_W'(DEADBAND));
  assign prop    = err_mag >> KP_SHIFT;
  assign duty_dn = (32'(duty_q) > RAMP_STEP) ? DUTY_W'(32'(duty_q) - RAMP_STEP) : '0;

  always_comb begin
    if (32'(prop) > DUTY_MAX)      duty_tgt = DUTY_W'(DUTY_MAX);
    else if (32'(prop) < MIN_DUTY) duty_tgt = DUTY_W'(MIN_DUTY);
    else                           duty_tgt = DUTY_W'(prop);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    state_d     = state_q;
    duty_d      = duty_q;
    cw_d        = cw_q;
    rev_brake_d = rev_brake_q;
    stall_d     = stall_q;
    min_err_d   = min_err_q;
    start_move  = 1'b0;

    if (!enable_d || (state_q == S_FAULT && clear_req)) begin
      state_d     = S_IDLE;
      duty_d      = '0;
      rev_brake_d = 1'b0;
      stall_d     = '0;
    end else if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (enable_q) begin
            start_move = 1'b1;
            cw_d       = want_cw;
          end
        end
        S_HOLD: begin
          if (!on_tgt) begin
            start_move = 1'b1;
            cw_d       = want_cw;
          end
        end
        S_MOVE: begin
          if (on_tgt) begin
            state_d = S_HOLD;
            duty_d  = '0;
            stall_d = '0;
          end else if (want_cw != cw_q) begin
            state_d = S_REV;
            duty_d  = duty_dn;
            stall_d = '0;
          end else if (err_mag < min_err_q) begin
            duty_d    = ramp_toward(duty_q, duty_tgt);
            min_err_d = err_mag;
            stall_d   = '0;
          end else if (stall_q == STALL_W'(STALL_TICKS - 1)) begin
            state_d = S_FAULT;
            duty_d  = '0;
            stall_d = '0;
          end else begin
            duty_d  = ramp_toward(duty_q, duty_tgt);
            stall_d = stall_q + 1'b1;
          end
        end
        S_REV: begin
          // Direction only flips after duty reached zero and one brake tick elapsed.
          if (duty_q != '0) begin
            duty_d = duty_dn;
          end else if (!rev_brake_q) begin
            rev_brake_d = 1'b1;
          end else begin
            rev_brake_d = 1'b0;
            cw_d        = ~cw_q;
            start_move  = 1'b1;
          end
        end
        S_FAULT: ;
        default: state_d = S_IDLE;
      endcase

      if (start_move) begin
        state_d   = S_MOVE;
        duty_d    = ramp_toward('0, duty_tgt);
        min_err_d = err_mag;
        stall_d   = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      enable_q    <= 1'b0;
      tick_cnt_q  <= '0;
      stall_q     <= '0;
      min_err_q   <= '0;
      duty_q      <= '0;
      cw_q        <= 1'b0;
      rev_brake_q <= 1'b0;
      display_q   <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      enable_q    <= enable_d;
      tick_cnt_q  <= tick_cnt_d;
      stall_q     <= stall_d;
      min_err_q   <= min_err_d;
      duty_q      <= duty_d;
      cw_q        <= cw_d;
      rev_brake_q <= rev_brake_d;
      display_q   <= display_d;
    end
  end

  assign motor_duty    = duty_q;
  assign clockwise     = cw_q;
  assign display_angle = display_q;
  assign brake  = (state_q == S_HOLD) || (state_q == S_FAULT) || (state_q == S_REV && rev_brake_q);
  assign pwm_on = (state_q == S_MOVE) || (state_q == S_REV && !rev_brake_q);

  always_comb begin
    status_reg                = '0;
    status_reg[ANGLE_W-1:0]   = display_q;
    status_reg[16]            = (state_q == S_HOLD);
    status_reg[17]            = (state_q == S_FAULT);
    status_reg[18]            = (state_q == S_MOVE) || (state_q == S_REV);
    status_reg[19]            = cw_q;
    status_reg[27:20]         = duty_q[DUTY_W-1 -: 8];
    status_reg[30:28]         = state_q;
  end

endmodule

// File: tb/tb_servo_position_controller.sv
// Directed bench for servo_position_controller with a fast control tick (TICK_DIV=4).
module tb_servo_position_controller;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_strobe;
  logic [31:0] input_reg;
  logic [11:0] current_angle;
  logic [7:0]  motor_duty;
  logic        clockwise, brake, pwm_on;
  logic [11:0] display_angle;
  logic [31:0] status_reg;

  int total = 0;
  int bad   = 0;
  int bcnt;

  servo_position_controller #(.TICK_DIV(TICK_DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_strobe    (cmd_strobe),
    .input_reg     (input_reg),
    .current_angle (current_angle),
    .motor_duty    (motor_duty),
    .clockwise     (clockwise),
    .brake         (brake),
    .pwm_on        (pwm_on),
    .display_angle (display_angle),
    .status_reg    (status_reg)
  );

  always #5 clk = ~clk;

  // Bench-side tick phase: tick edges are those where bcnt == TICK_DIV-1 beforehand.
  always @(posedge clk or posedge reset) begin
    if (reset) bcnt <= 0;
    else       bcnt <= (bcnt == TICK_DIV - 1) ? 0 : bcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int  k = 0;
    logic was;
    while (k < n) begin
      was = (bcnt == TICK_DIV - 1);
      @(posedge clk);
      #1;
      if (was) k++;
    end
  endtask

  // Strobe always lands on a non-tick edge so the new command is seen from the next tick on.
  task automatic strobe(input logic [11:0] tgt, input logic en, input logic clr);
    if (bcnt == TICK_DIV - 1) begin
      @(posedge clk);
      #1;
    end
    input_reg  = {14'd0, clr, en, 4'd0, tgt};
    cmd_strobe = 1'b1;
    @(posedge clk);
    #1;
    cmd_strobe = 1'b0;
    input_reg  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    cmd_strobe    = 1'b0;
    input_reg     = '0;
    current_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", status_reg, 32'h0);
    check("reset_duty", {24'd0, motor_duty}, 32'd0);
    @(negedge clk) reset = 1'b0;
    #1;

    // 1. Reset mid-MOVE at duty 40
    strobe(12'd2000, 1'b1, 1'b0);
    wait_ticks(5);
    check("t1_duty40", {24'd0, motor_duty}, 32'd40);
    reset = 1'b1;
    #1;
    check("t1_rst_duty", {24'd0, motor_duty}, 32'd0);
    check("t1_rst_pwm", {31'd0, pwm_on}, 32'd0);
    check("t1_rst_cw", {31'd0, clockwise}, 32'd0);
    check("t1_rst_brake", {31'd0, brake}, 32'd0);
    check("t1_rst_status", status_reg, 32'h0);
    @(negedge clk) reset = 1'b0;
    #1;
    wait_ticks(2);
    check("t1_post_status", status_reg, 32'h0);

    // 2. Ramp to saturation, then land inside the deadband
    strobe(12'd2000, 1'b1, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      wait_ticks(1);
      check($sformatf("t2_ramp%0d", k), {24'd0, motor_duty}, (8 * k > 255) ? 32'd255 : 32'(8 * k));
      if (k == 1) begin
        check("t2_cw", {31'd0, clockwise}, 32'd1);
        check("t2_pwm", {31'd0, pwm_on}, 32'd1);
        check("t2_state_move", {29'd0, status_reg[30:28]}, 32'd1);
      end
    end
    current_angle = 12'd1998;
    wait_ticks(1);
    check("t2_hold_state", {29'd0, status_reg[30:28]}, 32'd3);
    check("t2_hold_brake", {31'd0, brake}, 32'd1);
    check("t2_hold_duty", {24'd0, motor_duty}, 32'd0);
    check("t2_hold_pwm", {31'd0, pwm_on}, 32'd0);
    check("t2_on_target", {31'd0, status_reg[16]}, 32'd1);
    check("t2_display", {20'd0, display_angle}, 32'd1998);

    // 3. Wrap-around error in both directions and the half-circle tie
    strobe(12'd0, 1'b0, 1'b0);
    check("t3_disabled", {29'd0, status_reg[30:28]}, 32'd0);
    current_angle = 12'd4090;
    strobe(12'd10, 1'b1, 1'b0);
    wait_ticks(1);
    check("t3_wrap_cw", {31'd0, clockwise}, 32'd1);
    check("t3_wrap_duty8", {24'd0, motor_duty}, 32'd8);
    wait_ticks(2);
    check("t3_wrap_duty16", {24'd0, motor_duty}, 32'd16);
    strobe(12'd0, 1'b0, 1'b0);
    current_angle = 12'd10;
    strobe(12'd4090, 1'b1, 1'b0);
    wait_ticks(1);
    check("t3_wrap_ccw", {31'd0, clockwise}, 32'd0);
    check("t3_ccw_duty8", {24'd0, motor_duty}, 32'd8);
    strobe(12'd0, 1'b0, 1'b0);
    current_angle = 12'd0;
    strobe(12'd2048, 1'b1, 1'b0);
    wait_ticks(1);
    check("t3_half_cw", {31'd0, clockwise}, 32'd1);

    // 4. Reversal: ramp down, one brake tick, flip, ramp up
    strobe(12'd0, 1'b0, 1'b0);
    current_angle = 12'd1000;
    strobe(12'd2000, 1'b1, 1'b0);
    wait_ticks(8);
    check("t4_duty64", {24'd0, motor_duty}, 32'd64);
    check("t4_cw_before", {31'd0, clockwise}, 32'd1);
    strobe(12'd500, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      wait_ticks(1);
      check($sformatf("t4_down%0d", k), {24'd0, motor_duty}, 32'(64 - 8 * k));
      check($sformatf("t4_dir_held%0d", k), {31'd0, clockwise}, 32'd1);
    end
    check("t4_rev_state", {29'd0, status_reg[30:28]}, 32'd2);
    wait_ticks(1);
    check("t4_brake_on", {31'd0, brake}, 32'd1);
    check("t4_brake_duty", {24'd0, motor_duty}, 32'd0);
    wait_ticks(1);
    check("t4_brake_off", {31'd0, brake}, 32'd0);
    check("t4_cw_after", {31'd0, clockwise}, 32'd0);
    check("t4_up8", {24'd0, motor_duty}, 32'd8);
    wait_ticks(1);
    check("t4_up16", {24'd0, motor_duty}, 32'd16);

    // 5. Stall fault, sticky against target change, cleared by clear_fault
    strobe(12'd0, 1'b0, 1'b0);
    current_angle = 12'd1000;
    strobe(12'd1500, 1'b1, 1'b0);
    wait_ticks(1);
    check("t5_move", {29'd0, status_reg[30:28]}, 32'd1);
    wait_ticks(49);
    check("t5_still_move", {29'd0, status_reg[30:28]}, 32'd1);
    wait_ticks(1);
    check("t5_fault_state", {29'd0, status_reg[30:28]}, 32'd4);
    check("t5_fault_bit", {31'd0, status_reg[17]}, 32'd1);
    check("t5_fault_brake", {31'd0, brake}, 32'd1);
    check("t5_fault_duty", {24'd0, motor_duty}, 32'd0);
    check("t5_fault_pwm", {31'd0, pwm_on}, 32'd0);
    strobe(12'd3000, 1'b1, 1'b0);
    wait_ticks(2);
    check("t5_sticky", {29'd0, status_reg[30:28]}, 32'd4);
    strobe(12'd1500, 1'b1, 1'b1);
    check("t5_cleared", {29'd0, status_reg[30:28]}, 32'd0);
    check("t5_fault_bit_clr", {31'd0, status_reg[17]}, 32'd0);
    wait_ticks(1);
    check("t5_restart", {29'd0, status_reg[30:28]}, 32'd1);

    // 6. Emergency stop at duty 200
    strobe(12'd0, 1'b0, 1'b0);
    current_angle = 12'd0;
    strobe(12'd2000, 1'b1, 1'b0);
    wait_ticks(25);
    check("t6_duty200", {24'd0, motor_duty}, 32'd200);
    strobe(12'd2000, 1'b0, 1'b0);
    check("t6_stop_duty", {24'd0, motor_duty}, 32'd0);
    check("t6_stop_pwm", {31'd0, pwm_on}, 32'd0);
    check("t6_stop_state", {29'd0, status_reg[30:28]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
